// File: rtl/ysyx_24080014_exec_core.sv
// Execute stage of the single-cycle RV32I core: register file, ALU operand muxes,
// ALU and branch comparator. Only the register file holds state.
module ysyx_24080014_exec_core (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  input  logic [4:0]  rd,
  input  logic        RegWr,
  input  logic [31:0] rd_data,
  input  logic [31:0] pc,
  input  logic [31:0] imm,
  input  logic [2:0]  rs1_ctr,
  input  logic [2:0]  rs2_ctr,
  input  logic [3:0]  alu_ctl,
  input  logic        Equal_ctl,
  input  logic [2:0]  eq_ctl,
  output logic [31:0] rs1_data,
  output logic [31:0] rs2_data,
  output logic [31:0] alu_rs1,
  output logic [31:0] alu_rs2,
  output logic [31:0] alu_out,
  output logic        rd_wirte
);

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_XOR   = 4'd4,
    ALU_SLL   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_SLT   = 4'd8,
    ALU_SLTU  = 4'd9,
    ALU_PASSB = 4'd10
  } alu_op_e;

  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_EQ   = 3'd1,
    BR_NE   = 3'd2,
    BR_LT   = 3'd3,
    BR_GE   = 3'd4,
    BR_LTU  = 3'd5,
    BR_GEU  = 3'd6
  } br_op_e;

  logic [31:0] regs [32];
  logic [4:0]  shamt;

  // Entry 0 is kept at zero but reads of index 0 are forced to zero regardless.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= '0;
      end
    end else if (RegWr && (rd != 5'd0)) begin
      regs[rd] <= rd_data;
    end
  end

  assign rs1_data = (rs1_addr == 5'd0) ? 32'd0 : regs[rs1_addr];
  assign rs2_data = (rs2_addr == 5'd0) ? 32'd0 : regs[rs2_addr];

  always_comb begin
    alu_rs1 = 32'd0;
    case (rs1_ctr)
      3'd0:    alu_rs1 = rs1_data;
      3'd1:    alu_rs1 = pc;
      default: alu_rs1 = 32'd0;
    endcase
  end

  always_comb begin
    alu_rs2 = 32'd0;
    case (rs2_ctr)
      3'd0:    alu_rs2 = rs2_data;
      3'd1:    alu_rs2 = imm;
      3'd2:    alu_rs2 = 32'd4;
      default: alu_rs2 = 32'd0;
    endcase
  end

  assign shamt = alu_rs2[4:0];

  always_comb begin
    alu_out = 32'd0;
    case (alu_op_e'(alu_ctl))
      ALU_ADD:   alu_out = alu_rs1 + alu_rs2;
      ALU_SUB:   alu_out = alu_rs1 - alu_rs2;
      ALU_AND:   alu_out = alu_rs1 & alu_rs2;
      ALU_OR:    alu_out = alu_rs1 | alu_rs2;
      ALU_XOR:   alu_out = alu_rs1 ^ alu_rs2;
      ALU_SLL:   alu_out = alu_rs1 << shamt;
      ALU_SRL:   alu_out = alu_rs1 >> shamt;
      ALU_SRA:   alu_out = $unsigned($signed(alu_rs1) >>> shamt);
      ALU_SLT:   alu_out = {31'd0, $signed(alu_rs1) < $signed(alu_rs2)};
      ALU_SLTU:  alu_out = {31'd0, alu_rs1 < alu_rs2};
      ALU_PASSB: alu_out = alu_rs2;
      default:   alu_out = 32'd0;
    endcase
  end

  // Branches compare the raw register values, never the muxed ALU operands.
  always_comb begin
    rd_wirte = 1'b0;
    if (Equal_ctl) begin
      case (br_op_e'(eq_ctl))
        BR_EQ:   rd_wirte = (rs1_data == rs2_data);
        BR_NE:   rd_wirte = (rs1_data != rs2_data);
        BR_LT:   rd_wirte = ($signed(rs1_data) < $signed(rs2_data));
        BR_GE:   rd_wirte = ($signed(rs1_data) >= $signed(rs2_data));
        BR_LTU:  rd_wirte = (rs1_data < rs2_data);
        BR_GEU:  rd_wirte = (rs1_data >= rs2_data);
        default: rd_wirte = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_24080014_exec_core.sv
// Directed bench for ysyx_24080014_exec_core: register file, operand muxes,
// ALU and branch comparator against hand-computed values.
module tb_ysyx_24080014_exec_core;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs1_addr, rs2_addr, rd;
  logic        RegWr;
  logic [31:0] rd_data, pc, imm;
  logic [2:0]  rs1_ctr, rs2_ctr;
  logic [3:0]  alu_ctl;
  logic        Equal_ctl;
  logic [2:0]  eq_ctl;
  logic [31:0] rs1_data, rs2_data, alu_rs1, alu_rs2, alu_out;
  logic        rd_wirte;

  int checks = 0;
  int fails  = 0;

  ysyx_24080014_exec_core dut (
    .clk       (clk),
    .rst       (rst),
    .rs1_addr  (rs1_addr),
    .rs2_addr  (rs2_addr),
    .rd        (rd),
    .RegWr     (RegWr),
    .rd_data   (rd_data),
    .pc        (pc),
    .imm       (imm),
    .rs1_ctr   (rs1_ctr),
    .rs2_ctr   (rs2_ctr),
    .alu_ctl   (alu_ctl),
    .Equal_ctl (Equal_ctl),
    .eq_ctl    (eq_ctl),
    .rs1_data  (rs1_data),
    .rs2_data  (rs2_data),
    .alu_rs1   (alu_rs1),
    .alu_rs2   (alu_rs2),
    .alu_out   (alu_out),
    .rd_wirte  (rd_wirte)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      fails++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // One clocked register write; inputs change on the falling edge.
  task automatic applyStimulus(input logic [4:0] idx, input logic [31:0] data);
    @(negedge clk);
    rd      = idx;
    rd_data = data;
    RegWr   = 1'b1;
    @(posedge clk);
    #1;
    RegWr = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rs1_addr = '0; rs2_addr = '0; rd = '0; RegWr = 1'b0;
    rd_data = '0; pc = '0; imm = '0; rs1_ctr = '0; rs2_ctr = '0;
    alu_ctl = '0; Equal_ctl = 1'b0; eq_ctl = '0;

    // Reset clears the register file
    @(posedge clk);
    #1;
    for (int i = 1; i < 32; i++) begin
      @(negedge clk);
      rs1_addr = 5'(i);
      rs2_addr = 5'(i);
      #1;
      checkOutput($sformatf("reset_x%0d_p1", i), rs1_data, 32'd0);
      checkOutput($sformatf("reset_x%0d_p2", i), rs2_data, 32'd0);
    end
    applyStimulus(5'd5, 32'hDEADBEEF);
    rs1_addr = 5'd5;
    #1;
    checkOutput("reset_overrides_write", rs1_data, 32'd0);

    // Write/read and x0
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(5'd3, 32'h12345678);
    rs1_addr = 5'd3;
    #1;
    checkOutput("write_x3", rs1_data, 32'h12345678);
    applyStimulus(5'd0, 32'hFFFFFFFF);
    rs1_addr = 5'd0;
    rs2_addr = 5'd0;
    #1;
    checkOutput("x0_p1", rs1_data, 32'd0);
    checkOutput("x0_p2", rs2_data, 32'd0);

    // Read during write returns the old value until the edge
    @(negedge clk);
    rd = 5'd3; rd_data = 32'h1; RegWr = 1'b1; rs1_addr = 5'd3;
    #1;
    checkOutput("rdw_old", rs1_data, 32'h12345678);
    @(posedge clk);
    #1;
    RegWr = 1'b0;
    checkOutput("rdw_new", rs1_data, 32'h1);

    // Add/sub wrap
    applyStimulus(5'd1, 32'hFFFFFFFF);
    applyStimulus(5'd2, 32'h1);
    @(negedge clk);
    rs1_addr = 5'd1; rs2_addr = 5'd2; imm = 32'h1;
    rs1_ctr = 3'd0; rs2_ctr = 3'd1; alu_ctl = 4'd0;
    #1;
    checkOutput("add_wrap", alu_out, 32'h0);
    rs2_ctr = 3'd0; alu_ctl = 4'd1;
    #1;
    checkOutput("sub_reg", alu_out, 32'hFFFFFFFE);
    rs1_ctr = 3'd1; rs2_ctr = 3'd2; pc = 32'h80000000; alu_ctl = 4'd0;
    #1;
    checkOutput("mux_a_pc", alu_rs1, 32'h80000000);
    checkOutput("mux_b_four", alu_rs2, 32'h4);
    checkOutput("pc_plus4", alu_out, 32'h80000004);

    // Logic ops
    @(negedge clk);
    pc = 32'hF0F0F0F0; imm = 32'hFF00FF00; rs1_ctr = 3'd1; rs2_ctr = 3'd1;
    alu_ctl = 4'd2;
    #1;
    checkOutput("and", alu_out, 32'hF000F000);
    alu_ctl = 4'd3;
    #1;
    checkOutput("or", alu_out, 32'hFFF0FFF0);
    alu_ctl = 4'd4;
    #1;
    checkOutput("xor", alu_out, 32'h0FF00FF0);

    // Shifts use only B[4:0]; compares
    @(negedge clk);
    pc = 32'h80000000; imm = 32'h21; alu_ctl = 4'd5;
    #1;
    checkOutput("sll", alu_out, 32'h0);
    alu_ctl = 4'd6;
    #1;
    checkOutput("srl", alu_out, 32'h40000000);
    alu_ctl = 4'd7;
    #1;
    checkOutput("sra", alu_out, 32'hC0000000);
    imm = 32'h1; alu_ctl = 4'd8;
    #1;
    checkOutput("slt", alu_out, 32'h1);
    alu_ctl = 4'd9;
    #1;
    checkOutput("sltu", alu_out, 32'h0);
    @(negedge clk);
    imm = 32'h12345000; alu_ctl = 4'd10;
    #1;
    checkOutput("passb", alu_out, 32'h12345000);

    // Branches on x1=0xFFFFFFFF, x2=1; ALU operands point elsewhere
    @(negedge clk);
    rs1_addr = 5'd1; rs2_addr = 5'd2; Equal_ctl = 1'b1; eq_ctl = 3'd1;
    #1;
    checkOutput("beq", {31'd0, rd_wirte}, 32'd0);
    eq_ctl = 3'd2;
    #1;
    checkOutput("bne", {31'd0, rd_wirte}, 32'd1);
    eq_ctl = 3'd3;
    #1;
    checkOutput("blt", {31'd0, rd_wirte}, 32'd1);
    eq_ctl = 3'd4;
    #1;
    checkOutput("bge", {31'd0, rd_wirte}, 32'd0);
    @(negedge clk);
    eq_ctl = 3'd5;
    #1;
    checkOutput("bltu", {31'd0, rd_wirte}, 32'd0);
    eq_ctl = 3'd6;
    #1;
    checkOutput("bgeu", {31'd0, rd_wirte}, 32'd1);
    eq_ctl = 3'd2; Equal_ctl = 1'b0;
    #1;
    checkOutput("bne_disabled", {31'd0, rd_wirte}, 32'd0);
    Equal_ctl = 1'b1; eq_ctl = 3'd1; rs2_addr = 5'd1;
    #1;
    checkOutput("beq_equal", {31'd0, rd_wirte}, 32'd1);
    eq_ctl = 3'd7;
    #1;
    checkOutput("eq_ctl7", {31'd0, rd_wirte}, 32'd0);

    // Illegal selects
    @(negedge clk);
    pc = 32'h12345678; imm = 32'h9ABCDEF0; alu_ctl = 4'd15;
    #1;
    checkOutput("alu_ctl15", alu_out, 32'h0);
    rs1_ctr = 3'd2;
    #1;
    checkOutput("rs1_ctr2", alu_rs1, 32'h0);
    rs1_ctr = 3'd7; rs2_ctr = 3'd7;
    #1;
    checkOutput("rs1_ctr7", alu_rs1, 32'h0);
    checkOutput("rs2_ctr7", alu_rs2, 32'h0);

    // Mid-program reset acts only at the next edge
    @(negedge clk);
    rs1_addr = 5'd1; rs2_addr = 5'd3; rst = 1'b1;
    #1;
    checkOutput("midrst_before", rs1_data, 32'hFFFFFFFF);
    @(posedge clk);
    #1;
    checkOutput("midrst_x1", rs1_data, 32'h0);
    checkOutput("midrst_x3", rs2_data, 32'h0);
    rst = 1'b0;

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
